// File: rtl/intr_pkg.sv
// Shared types and constants for the ND-100 interrupt/IDENT responder.
package intr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PEND,
        ST_ACK,
        ST_WAITREL
    } ident_state_e;

    localparam logic [3:0] PL10 = 4'd10;
    localparam logic [3:0] PL11 = 4'd11;
    localparam logic [3:0] PL12 = 4'd12;
    localparam logic [3:0] PL13 = 4'd13;

    localparam int IDENT_DW = 16;
    localparam int IDENT_CW = 9;

endpackage

// File: rtl/intr_ident_responder_if.sv
// Bus-side and device-side signal bundle of one interrupt source.
interface intr_ident_responder_if #(
    parameter int CNT_W = 4
);
    logic             IRQ_REQ;
    logic             IE;
    logic             CLR_PEND;
    logic             IDENTN;
    logic [3:0]       IDL_3_0;
    logic             PRIOIN;
    logic             PRIOOUT;
    logic             BINTN;
    logic [15:0]      DOUT_15_0;
    logic             DOE;
    logic [CNT_W-1:0] PEND_CNT;
    logic             OVR;

    modport master (
        output IRQ_REQ, IE, CLR_PEND, IDENTN, IDL_3_0, PRIOIN,
        input  PRIOOUT, BINTN, DOUT_15_0, DOE, PEND_CNT, OVR
    );

    modport slave (
        input  IRQ_REQ, IE, CLR_PEND, IDENTN, IDL_3_0, PRIOIN,
        output PRIOOUT, BINTN, DOUT_15_0, DOE, PEND_CNT, OVR
    );
endinterface

// File: rtl/intr_req_counter.sv
// Saturating pending-request counter with synchronous clear and sticky overflow.
module intr_req_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt,
    output logic [CNT_W-1:0] cnt_next,
    output logic             ovr
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovr_q, ovr_d;

    always_comb begin
        cnt_d = cnt_q;
        ovr_d = ovr_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && !dec) begin
            if (cnt_q == CNT_MAX) ovr_d = 1'b1;
            else                  cnt_d = cnt_q + 1'b1;
        end else if (dec && !inc) begin
            // A clear during an ident cycle can leave nothing to consume.
            if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
        end
    end

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            ovr_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovr_q <= ovr_d;
        end
    end

    assign cnt      = cnt_q;
    assign cnt_next = cnt_d;
    assign ovr      = ovr_q;
endmodule

// File: rtl/intr_ident_responder.sv
// Device end of the interrupt/IDENT handshake: raises BINTN, claims the daisy chain, returns the ident code.
module intr_ident_responder
    import intr_pkg::*;
#(
    parameter logic [3:0]          LEVEL      = PL12,
    parameter logic [IDENT_CW-1:0] IDENT_CODE = 9'h001,
    parameter int                  CNT_W      = 4
) (
    input  logic                    MCLK,
    input  logic                    CLEAR,
    intr_ident_responder_if.slave   bus
);
    localparam logic [IDENT_DW-1:0] IDENT_WORD = {{(IDENT_DW - IDENT_CW){1'b0}}, IDENT_CODE};

    ident_state_e        state_q, state_d;
    logic                identn_prev_q;
    logic                bintn_q, bintn_d;
    logic                doe_q, doe_d;
    logic [IDENT_DW-1:0] dout_q, dout_d;

    logic [CNT_W-1:0] cnt, cnt_next;
    logic             ovr;
    logic             dec, claim, level_hit, identn_fall, accept, in_cycle;

    assign level_hit   = (bus.IDL_3_0 == LEVEL);
    assign claim       = (state_q == ST_PEND) && bus.IE;
    assign identn_fall = identn_prev_q && !bus.IDENTN;
    assign accept      = claim && identn_fall && level_hit && bus.PRIOIN;
    assign in_cycle    = (state_q == ST_ACK) || (state_q == ST_WAITREL);
    assign dec         = (state_q == ST_WAITREL) && bus.IDENTN;

    intr_req_counter #(.CNT_W(CNT_W)) u_req_counter (
        .clk      (MCLK),
        .rst      (CLEAR),
        .clr      (bus.CLR_PEND),
        .inc      (bus.IRQ_REQ),
        .dec      (dec),
        .cnt      (cnt),
        .cnt_next (cnt_next),
        .ovr      (ovr)
    );

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE, ST_PEND: begin
                if (accept)              state_d = ST_ACK;
                else if (cnt_next != '0) state_d = ST_PEND;
                else                     state_d = ST_IDLE;
            end
            ST_ACK:     state_d = ST_WAITREL;
            ST_WAITREL: begin
                if (bus.IDENTN) state_d = (cnt_next != '0) ? ST_PEND : ST_IDLE;
            end
            default:    state_d = ST_IDLE;
        endcase
    end

    // Outputs follow the next state so they appear one edge after the cause.
    always_comb begin
        bintn_d = !(bus.IE && (state_d != ST_IDLE));
        doe_d   = (state_d == ST_ACK) || (state_d == ST_WAITREL);
        dout_d  = doe_d ? IDENT_WORD : '0;
    end

    always_ff @(posedge MCLK or posedge CLEAR) begin
        if (CLEAR) begin
            state_q       <= ST_IDLE;
            identn_prev_q <= 1'b1;
            bintn_q       <= 1'b1;
            doe_q         <= 1'b0;
            dout_q        <= '0;
        end else begin
            state_q       <= state_d;
            identn_prev_q <= bus.IDENTN;
            bintn_q       <= bintn_d;
            doe_q         <= doe_d;
            dout_q        <= dout_d;
        end
    end

    // Grant is withheld only for an IDENT cycle this device owns; stale cycles pass through.
    assign bus.PRIOOUT   = bus.PRIOIN &&
                           !(!bus.IDENTN && level_hit && ((claim && identn_prev_q) || in_cycle));
    assign bus.BINTN     = bintn_q;
    assign bus.DOE       = doe_q;
    assign bus.DOUT_15_0 = dout_q;
    assign bus.PEND_CNT  = cnt;
    assign bus.OVR       = ovr;
endmodule

// File: doc/intr_ident_responder.md
Name: intr_ident_responder

Overview:
- Device-side end of the ND-100 bus interrupt/IDENT protocol. The interrupt controller samples BINTxxN and the CPU runs IDENT PLxx; this block is what an I/O device instantiates to raise those requests and answer them.
- Queues device interrupt events and drives one active-low bus interrupt line for its level.
- Claims the IDENT cycle through the priority daisy chain and returns the device ident code on the data bus.
- Sits in the I/O-interface CGAs, one instance per interrupt source.

Parameters:
- LEVEL, 4'd12, interrupt level served (10..13); compared against IDL_3_0.
- IDENT_CODE, 9'h001, device ident code returned during IDENT.
- CNT_W, 4, width of the pending-request counter; saturates at 2^CNT_W-1.

Ports:
- MCLK  in  1  system clock; all state changes on rising edge.
- CLEAR  in  1  asynchronous active-high reset.
- IRQ_REQ  in  1  device event; each cycle it is high queues one request.
- IE  in  1  device interrupt enable from the device control register.
- CLR_PEND  in  1  synchronous: discard all queued requests.
- IDENTN  in  1  active-low IDENT cycle strobe, synchronous to MCLK.
- IDL_3_0  in  4  level being identified; valid while IDENTN is low.
- PRIOIN  in  1  daisy-chain grant in; high means no upstream device claimed.
- PRIOOUT  out  1  daisy-chain grant out to the next device.
- BINTN  out  1  active-low bus interrupt request for LEVEL (registered).
- DOUT_15_0  out  16  ident data, {7'b0, IDENT_CODE} while DOE=1, else 0.
- DOE  out  1  data output enable (registered).
- PEND_CNT  out  CNT_W  queued request count.
- OVR  out  1  sticky: a request was lost at saturation.

Behaviour:
- Reset (CLEAR=1, asynchronous): state=IDLE, PEND_CNT=0, OVR=0, BINTN=1, DOE=0, DOUT=0. Because reset is asynchronous, an ident cycle in progress is abandoned immediately and DOE drops in the same instant.
- States: IDLE (cnt=0), PEND (cnt>0), ACK (driving ident), WAITREL (waiting for IDENTN high).
- Counter (CNT_W bits), evaluated each edge in priority order:
  - CLR_PEND: next=0.
  - Otherwise next = cnt + inc - dec, where inc=IRQ_REQ and dec=ack-completion.
  - inc and dec in the same cycle: count unchanged.
  - inc at saturation: count holds and OVR is set. OVR clears only on CLEAR.
  - dec when cnt=0 (CLR_PEND hit during ACK): count stays 0, no underflow.
- claim = (state==PEND) & IE. This is a registered term.
- BINTN is registered: BINTN <= ~(next-state claim). One cycle of latency from IRQ_REQ to BINTN low. IE low releases BINTN the next cycle; requests stay queued.
- PRIOOUT = PRIOIN & ~(claim & ~IDENTN & IDL_3_0==LEVEL). Combinational pass-through, so no per-device delay accumulates along the chain.
- PEND -> ACK: IDENTN=0, IDL_3_0==LEVEL, PRIOIN=1, claim=1.
  - DOE=1 and DOUT valid from the next edge (1-cycle latency).
- ACK -> WAITREL: after exactly one cycle in ACK. DOE and DOUT are held.
- WAITREL while IDENTN=0: DOE held.
- WAITREL, on the first cycle IDENTN=1:
  - DOE=0 and DOUT=0 on that edge.
  - dec=1 on that edge (one request consumed).
  - Next state = PEND if the resulting cnt>0, else IDLE.
- Once in ACK or WAITREL, the cycle completes regardless of IE, CLR_PEND or PRIOIN changes.
- IDENT at a different level, or with PRIOIN=0: no response, state unchanged.
- IDENTN already low when claim first rises: no claim. The block waits for the next IDENTN falling edge, detected from the registered previous IDENTN.
- BINTN stays asserted during ACK/WAITREL while cnt-1>0; otherwise it deasserts on the release edge.

Decomposition:
- Shared package (intr_pkg):
  - state encoding typedef (IDLE/PEND/ACK/WAITREL);
  - level constants PL10..PL13;
  - IDENT data width 16;
  - ident code width 9.
- One natural sub-module: intr_req_counter, the saturating up/down counter with clear and overflow flag. The FSM, daisy chain and data drive stay in the top block.

Test Plan:
- Basic handshake, LEVEL=12, IE=1, PRIOIN=1:
  - Stimulus: IRQ_REQ 1 cycle.
  - Next edge: BINTN=0, PEND_CNT=1.
  - Stimulus: IDENTN low 4 cycles with IDL=12.
  - Response: PRIOOUT=0; DOE=1 and DOUT=16'h0001 from cycle 2.
  - On IDENTN high: DOE=0, PEND_CNT=0, BINTN=1.
- Queueing: 3 IRQ_REQ pulses, then 2 IDENT cycles.
  - PEND_CNT goes 3→2→1.
  - BINTN stays 0 throughout.
  - OVR=0.
- Saturation and simultaneous events:
  - Hold IRQ_REQ 20 cycles (CNT_W=4): PEND_CNT=15, OVR=1.
  - IRQ_REQ=1 on the IDENTN release edge: count unchanged.
- Wrong level and grant blocked:
  - IDL=11, or PRIOIN=0, with cnt=1: DOE stays 0, PEND_CNT=1.
  - PRIOOUT=PRIOIN.
  - With IDL=11, a PRIOIN toggle appears on PRIOOUT the same cycle.
- IE and CLR_PEND during ACK:
  - Drop IE and pulse CLR_PEND while DOE=1.
  - DOUT is still 16'h0001 until IDENTN rises.
  - Then PEND_CNT=0, state IDLE, no underflow.
- Reset mid-operation:
  - Assert CLEAR with DOE=1 between clock edges: DOE=0 and BINTN=1 immediately.
  - PEND_CNT=0, OVR=0 after release.
